// File: rtl/t05_pc_ras.sv
// Program-counter unit with next-PC mode select, circular return-address
// stack and misaligned-target trap redirect.
//
// Ports:
//   clk, clr      clock (rising edge), asynchronous active-high reset
//   stall         holds PC and RAS and suppresses the error pulses
//   mode          next-PC select (HOLD/SEQ/BRANCH/JAL/JALR/RET/TRAP)
//   br_taken      branch condition, only looked at in BRANCH mode
//   link_en       push pc+4 on the RAS during JAL/JALR
//   imm, rs1      sign-extended offset and JALR base register
//   pc_val        registered fetch address
//   pc_plus4      combinational pc_val+4, also the link value
//   ras_count     number of valid RAS entries
//   misalign_err  one-cycle pulse: last redirect target was misaligned
//   ras_underflow one-cycle pulse: RET issued with an empty RAS
module t05_pc_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  localparam int unsigned    PW        = $clog2(RAS_DEPTH),
  localparam int unsigned    CW        = PW + 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            stall,
  input  logic [2:0]      mode,
  input  logic            br_taken,
  input  logic            link_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc_val,
  output logic [XLEN-1:0] pc_plus4,
  output logic [CW-1:0]   ras_count,
  output logic            misalign_err,
  output logic            ras_underflow
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SEQ  = 3'd1,
    M_BR   = 3'd2,
    M_JAL  = 3'd3,
    M_JALR = 3'd4,
    M_RET  = 3'd5,
    M_TRAP = 3'd6,
    M_RSV  = 3'd7
  } mode_e;

  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            und_q, und_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] jr;
  logic [PW-1:0]   top;
  logic            chk;
  logic            push;
  logic            pop;
  logic            und;
  logic            mis;
  logic            wr_en;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign top      = wp_q - 1'b1;

  always_comb begin
    tgt  = pc_q;
    chk  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    und  = 1'b0;
    jr   = rs1 + imm;
    jr[0] = 1'b0;
    case (mode_e'(mode))
      M_SEQ: tgt = pc_plus4;
      M_BR: begin
        if (br_taken) begin
          tgt = pc_q + imm;
          chk = 1'b1;
        end else begin
          tgt = pc_plus4;
        end
      end
      M_JAL: begin
        tgt  = pc_q + imm;
        chk  = 1'b1;
        push = link_en;
      end
      M_JALR: begin
        tgt  = jr;
        chk  = 1'b1;
        push = link_en;
      end
      M_RET: begin
        chk = 1'b1;
        if (cnt_q != '0) begin
          tgt = ras_q[top];
          pop = 1'b1;
        end else begin
          // empty stack: fall back to the JALR target
          tgt = jr;
          und = 1'b1;
        end
      end
      M_TRAP: tgt = TRAP_VEC;
      default: tgt = pc_q;
    endcase
    mis = chk & (tgt[1:0] != 2'b00);
  end

  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    mis_d = 1'b0;
    und_d = 1'b0;
    wr_en = 1'b0;
    if (!stall) begin
      pc_d  = mis ? TRAP_VEC : tgt;
      mis_d = mis;
      und_d = und;
      if (!mis && push) begin
        wr_en = 1'b1;
        wp_d  = wp_q + 1'b1;
        // full stack: the write lands on the oldest entry
        if (cnt_q != FULL) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (!mis && pop) begin
        wp_d  = wp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= RESET_VEC;
      wp_q  <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      und_q <= und_d;
    end
  end

  // stack storage needs no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_q[wp_q] <= pc_plus4;
    end
  end

  assign pc_val        = pc_q;
  assign ras_count     = cnt_q;
  assign misalign_err  = mis_q;
  assign ras_underflow = und_q;

endmodule

// File: tb/tb_t05_pc_ras.sv
// Bench for t05_pc_ras: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations at key points.
module tb_t05_pc_ras;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        br_taken = 1'b0;
  logic        link_en = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] pc_val;
  logic [31:0] pc_plus4;
  logic [2:0]  ras_count;
  logic        misalign_err;
  logic        ras_underflow;

  int n_chk = 0;
  int n_fail = 0;

  t05_pc_ras #(
    .XLEN(32),
    .RAS_DEPTH(DEPTH),
    .RESET_VEC(RV),
    .TRAP_VEC(TV)
  ) dut (
    .clk(clk),
    .clr(clr),
    .stall(stall),
    .mode(mode),
    .br_taken(br_taken),
    .link_en(link_en),
    .imm(imm),
    .rs1(rs1),
    .pc_val(pc_val),
    .pc_plus4(pc_plus4),
    .ras_count(ras_count),
    .misalign_err(misalign_err),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: a plain stack of return addresses
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_mis;
  bit          m_und;
  logic [31:0] m_t;
  logic [31:0] m_jr;
  bit          m_chk;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_pc = RV;
      m_ras.delete();
      m_mis = 0;
      m_und = 0;
    end else if (stall) begin
      m_mis = 0;
      m_und = 0;
    end else begin
      m_t = m_pc;
      m_chk = 0;
      m_push = 0;
      m_pop = 0;
      m_und = 0;
      m_jr = (rs1 + imm) & 32'hFFFF_FFFE;
      if (mode == 3'd1) m_t = m_pc + 4;
      if (mode == 3'd2) begin
        m_t = br_taken ? m_pc + imm : m_pc + 4;
        m_chk = br_taken;
      end
      if (mode == 3'd3) begin
        m_t = m_pc + imm;
        m_chk = 1;
        m_push = link_en;
      end
      if (mode == 3'd4) begin
        m_t = m_jr;
        m_chk = 1;
        m_push = link_en;
      end
      if (mode == 3'd5) begin
        m_chk = 1;
        if (m_ras.size() > 0) begin
          m_t = m_ras[m_ras.size()-1];
          m_pop = 1;
        end else begin
          m_t = m_jr;
          m_und = 1;
        end
      end
      if (mode == 3'd6) m_t = TV;
      m_mis = m_chk && (m_t[1:0] != 2'b00);
      if (!m_mis && m_push) begin
        m_ras.push_back(m_pc + 4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (!m_mis && m_pop) void'(m_ras.pop_back());
      m_pc = m_mis ? TV : m_t;
    end
  end

  always @(negedge clk) begin
    if (!clr) begin
      chk("m_pc", pc_val, m_pc);
      chk("m_pc4", pc_plus4, m_pc + 32'd4);
      chk("m_cnt", {29'd0, ras_count}, m_ras.size());
      chk("m_mis", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("m_und", {31'd0, ras_underflow}, {31'd0, m_und});
    end
  end

  task automatic step(input logic [2:0] md, input logic bt,
                      input logic le, input logic [31:0] im,
                      input logic [31:0] r1);
    mode = md;
    br_taken = bt;
    link_en = le;
    imm = im;
    rs1 = r1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_pc", pc_val, 32'h0);
    chk("rst_cnt", {29'd0, ras_count}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    repeat (3) step(3'd1, 0, 0, 0, 0);
    chk("seq3", pc_val, 32'hC);
    step(3'd1, 0, 0, 0, 0);
    chk("seq4", pc_val, 32'h10);
    step(3'd2, 1, 0, 32'hFFFF_FFF8, 0);
    chk("br_t", pc_val, 32'h8);
    step(3'd2, 0, 0, 32'h20, 0);
    chk("br_nt", pc_val, 32'hC);

    step(3'd3, 0, 0, 32'h34, 0);
    chk("jal_nolink", pc_val, 32'h40);
    chk("cnt_nolink", {29'd0, ras_count}, 32'd0);
    step(3'd3, 0, 1, 32'h100, 0);
    chk("jal_link", pc_val, 32'h140);
    chk("cnt1", {29'd0, ras_count}, 32'd1);
    step(3'd5, 0, 0, 0, 0);
    chk("ret", pc_val, 32'h44);
    chk("cnt0", {29'd0, ras_count}, 32'd0);

    step(3'd4, 0, 0, 0, 0);
    chk("jalr0", pc_val, 32'h0);
    repeat (5) step(3'd3, 0, 1, 32'h100, 0);
    chk("nest_pc", pc_val, 32'h500);
    chk("nest_sat", {29'd0, ras_count}, 32'd4);
    step(3'd5, 0, 0, 0, 0);
    chk("ret1", pc_val, 32'h404);
    step(3'd5, 0, 0, 0, 0);
    chk("ret2", pc_val, 32'h304);
    step(3'd5, 0, 0, 0, 0);
    chk("ret3", pc_val, 32'h204);
    step(3'd5, 0, 0, 0, 0);
    chk("ret4", pc_val, 32'h104);
    chk("ret4_cnt", {29'd0, ras_count}, 32'd0);
    step(3'd5, 0, 0, 0, 32'h80);
    chk("ret_uf", pc_val, 32'h80);
    chk("uf_pulse", {31'd0, ras_underflow}, 32'd1);
    step(3'd0, 0, 1, 0, 0);
    chk("uf_clear", {31'd0, ras_underflow}, 32'd0);
    chk("hold", pc_val, 32'h80);

    step(3'd3, 0, 1, 32'h10, 0);
    chk("jal_90", pc_val, 32'h90);
    step(3'd4, 0, 0, 0, 32'h1001);
    chk("jalr_b0", pc_val, 32'h1000);
    step(3'd4, 0, 1, 0, 32'h1002);
    chk("jalr_mis", pc_val, TV);
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis_cnt", {29'd0, ras_count}, 32'd1);
    step(3'd2, 1, 0, 32'h2, 0);
    chk("br_mis", pc_val, TV);
    chk("br_mis_p", {31'd0, misalign_err}, 32'd1);
    step(3'd1, 0, 0, 0, 0);
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);

    step(3'd4, 0, 0, 0, 32'hFFFF_FFFC);
    chk("top_pc", pc_val, 32'hFFFF_FFFC);
    chk("pc4_wrap", pc_plus4, 32'h0);
    step(3'd1, 0, 0, 0, 0);
    chk("seq_wrap", pc_val, 32'h0);
    stall = 1'b1;
    step(3'd6, 0, 0, 0, 0);
    chk("stall_trap", pc_val, 32'h0);
    step(3'd3, 0, 1, 32'h2, 0);
    chk("stall_mis", {31'd0, misalign_err}, 32'd0);
    chk("stall_cnt", {29'd0, ras_count}, 32'd1);
    stall = 1'b0;
    step(3'd6, 0, 0, 0, 0);
    chk("trap", pc_val, TV);

    step(3'd3, 0, 1, 32'h100, 0);
    step(3'd3, 0, 1, 32'h100, 0);
    chk("pre_clr_cnt", {29'd0, ras_count}, 32'd3);
    #1;
    clr = 1'b1;
    #1;
    chk("clr_pc", pc_val, RV);
    chk("clr_cnt", {29'd0, ras_count}, 32'd0);
    clr = 1'b0;
    step(3'd1, 0, 0, 0, 0);
    chk("post_clr", pc_val, 32'h4);
    step(3'd5, 0, 0, 0, 32'h20);
    chk("post_clr_uf", pc_val, 32'h20);
    step(3'd7, 0, 1, 0, 0);
    chk("rsv_hold", pc_val, 32'h20);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/t05_pc_ras.md
Name: t05_pc_ras

Overview:
- Parametrised program-counter unit for the team_05 RV32-style core. Generalises the single-mode PC register:
  - configurable width and reset/trap vectors;
  - explicit next-PC mode select (sequential, conditional branch, JAL, JALR, return, trap);
  - circular return-address stack (RAS) for call/return prediction;
  - misaligned-target detection.
- Sits between the control unit/ALU and instruction memory. Drives the fetch address every cycle.

Parameters:
- XLEN, 32, address/data width in bits (>= 8).
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).
- RESET_VEC, 32'h0000_0000, PC value after reset.
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap or misaligned target.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- stall  in  1  hold PC and RAS; overrides every mode.
- mode  in  3  next-PC select: 0 HOLD, 1 SEQ, 2 BRANCH, 3 JAL, 4 JALR, 5 RET, 6 TRAP, 7 reserved (treated as HOLD).
- br_taken  in  1  branch condition from ALU; used only in BRANCH.
- link_en  in  1  push pc+4 onto RAS during JAL/JALR.
- imm  in  XLEN  signed byte offset, already sign-extended.
- rs1  in  XLEN  JALR base register value.
- pc_val  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc_val+4 modulo 2^XLEN (combinational; also the link value).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
- misalign_err  out  1  registered one-cycle pulse: last redirect target was misaligned.
- ras_underflow  out  1  registered one-cycle pulse: RET issued with empty RAS.

Behaviour:
- Reset (clr=1, async):
  - pc_val=RESET_VEC; ras_count=0; RAS write pointer=0;
  - misalign_err=0; ras_underflow=0; RAS entry contents don't-care.
- Latency:
  - All state updates on the rising clk edge.
  - Target computed from the current cycle's inputs appears on pc_val one cycle later.
- Target per mode (all adds modulo 2^XLEN, wrap silently):
  - HOLD/7: target = pc_val.
  - SEQ: target = pc_val+4.
  - BRANCH: br_taken=1 gives target = pc_val+imm; br_taken=0 gives target = pc_val+4.
  - JAL: target = pc_val+imm.
  - JALR: target = (rs1+imm) with bit0 forced to 0.
  - RET with ras_count>0: target = top RAS entry; pop (pointer-1, count-1).
  - RET with ras_count=0: target = (rs1+imm) with bit0 cleared (JALR fallback); ras_underflow=1 next cycle.
  - TRAP: target = TRAP_VEC; RAS unchanged.
- Misalignment:
  - Checked for BRANCH-taken, JAL, JALR and RET targets only.
  - If target[1:0]!=0: pc_val<=TRAP_VEC; misalign_err=1 next cycle; no RAS push or pop occurs.
- RAS push:
  - Happens on JAL/JALR with link_en=1 and an aligned target.
  - Writes pc_val+4 at the pointer, then pointer+1 (mod RAS_DEPTH).
  - ras_count saturates at RAS_DEPTH; a push when full overwrites the oldest entry.
  - link_en is ignored in every other mode.
- Stall=1:
  - pc_val, RAS and ras_count unchanged; no push or pop.
  - misalign_err and ras_underflow drive 0.
  - Stall has priority over TRAP.
- Pulses: misalign_err and ras_underflow are high for exactly one cycle per event and clear the following cycle unless re-triggered.
- clr asserted mid-operation: immediate return to reset state; RAS contents are lost (count=0).

Test Plan:
- Reset, then mode=SEQ for 3 cycles -> pc_val 0x0, 0x4, 0x8, 0xC; ras_count=0.
- At pc=0x10: BRANCH imm=-8, br_taken=1 -> pc=0x08. BRANCH imm=0x20, br_taken=0 -> pc=0x0C.
- At pc=0x40: JAL imm=0x100, link_en=1 -> pc=0x140, ras_count=1. At 0x140: RET -> pc=0x44, ras_count=0.
- Five nested JAL+link with RAS_DEPTH=4 (pcs 0x0, 0x100, 0x200, 0x300, 0x400; imm=0x100 each):
  - ras_count saturates at 4.
  - Four RETs return 0x404, 0x304, 0x204, 0x104.
  - Fifth RET with rs1=0x80, imm=0 -> pc=0x80, ras_underflow pulses one cycle.
- JALR rs1=0x1001, imm=0 -> pc=0x1000 (bit0 cleared). JALR rs1=0x1002 -> pc=TRAP_VEC, misalign_err pulses, ras_count unchanged.
- Wrap and priority:
  - pc=0xFFFF_FFFC, SEQ -> pc=0x0.
  - stall=1 with mode=TRAP -> pc unchanged.
  - Assert clr asynchronously mid-cycle after 2 pushes -> pc=RESET_VEC, ras_count=0 before the next edge.
